// File: rtl/pudding_dac_ctrl.sv
// Command sequencer for the PUDDING dual DAC: chain/state registers, enable groups, thermometer load.
// Define PUDDING_DAC_BLANK_EN to make COMMIT blank state_en for two cycles around the state update.
module pudding_dac_ctrl #(
    parameter int N_UNITS = 128,
    parameter int N_EN    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [7:0]         cmd_data,
    output logic [N_UNITS-1:0] daisy_on,
    output logic [N_UNITS-1:0] state_on,
    output logic [N_EN-1:0]    daisy_en,
    output logic [N_EN-1:0]    state_en,
    output logic               done
);

    localparam logic [2:0] OP_SHIFT   = 3'b000;
    localparam logic [2:0] OP_COMMIT  = 3'b001;
    localparam logic [2:0] OP_CAPTURE = 3'b010;
    localparam logic [2:0] OP_THERMO  = 3'b011;
    localparam logic [2:0] OP_SET_EN  = 3'b100;

`ifdef PUDDING_DAC_BLANK_EN
    typedef enum logic [1:0] {IDLE, LOAD, BLANK0, BLANK1} state_t;
`else
    typedef enum logic {IDLE, LOAD} state_t;
`endif

    state_t          fsm;
    state_t          fsm_next;
    logic [6:0]      cnt;
    logic [7:0]      k;
    logic [N_EN-1:0] state_en_reg;
    logic            accept;
    logic            thermo_bit;

    assign cmd_ready  = (fsm == IDLE) && !rst;
    assign accept     = cmd_valid && cmd_ready;
    // Bit shifted at step i lands at position 127-i after the full load.
    assign thermo_bit = ({1'b0, 7'd127 - cnt} < k);

`ifdef PUDDING_DAC_BLANK_EN
    assign state_en = (fsm == BLANK0 || fsm == BLANK1) ? '0 : state_en_reg;
`else
    assign state_en = state_en_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE: begin
                if (accept && cmd_op == OP_THERMO) begin
                    fsm_next = LOAD;
                end
`ifdef PUDDING_DAC_BLANK_EN
                else if (accept && cmd_op == OP_COMMIT) begin
                    fsm_next = BLANK0;
                end
`endif
            end
            LOAD: begin
                if (cnt == 7'd127) begin
                    fsm_next = IDLE;
                end
            end
`ifdef PUDDING_DAC_BLANK_EN
            BLANK0: fsm_next = BLANK1;
            BLANK1: fsm_next = IDLE;
`endif
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            daisy_on     <= '0;
            state_on     <= '0;
            daisy_en     <= '0;
            state_en_reg <= '0;
            done         <= 1'b0;
            cnt          <= '0;
            k            <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_SHIFT: begin
                                daisy_on <= {daisy_on[N_UNITS-2:0], cmd_data[0]};
                                done     <= 1'b1;
                            end
                            OP_COMMIT: begin
`ifndef PUDDING_DAC_BLANK_EN
                                state_on <= daisy_on;
                                done     <= 1'b1;
`endif
                            end
                            OP_CAPTURE: begin
                                daisy_on <= state_on;
                                done     <= 1'b1;
                            end
                            OP_THERMO: begin
                                k   <= (cmd_data > 8'd128) ? 8'd128 : cmd_data;
                                cnt <= '0;
                            end
                            OP_SET_EN: begin
                                state_en_reg <= cmd_data[3:0];
                                daisy_en     <= cmd_data[7:4];
                                done         <= 1'b1;
                            end
                            default: done <= 1'b1;
                        endcase
                    end
                end
                LOAD: begin
                    daisy_on <= {daisy_on[N_UNITS-2:0], thermo_bit};
                    cnt      <= cnt + 7'd1;
                    if (cnt == 7'd127) begin
                        done <= 1'b1;
                    end
                end
`ifdef PUDDING_DAC_BLANK_EN
                BLANK0: state_on <= daisy_on;
                BLANK1: done <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pudding_dac_ctrl.sv
// Directed bench for pudding_dac_ctrl: transaction-level model checked every cycle plus literal checks.
// Follows PUDDING_DAC_BLANK_EN the same way the design does.
module tb_pudding_dac_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'b000;
    logic [7:0]   cmd_data = 8'h00;
    logic [127:0] daisy_on;
    logic [127:0] state_on;
    logic [3:0]   daisy_en;
    logic [3:0]   state_en;
    logic         done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    int done_cnt = 0;
    int ready_low_cnt = 0;
    int sen_zero_cnt = 0;

    // Model state: architectural registers plus "busy for N more edges, then finish X".
    logic [127:0] m_daisy = '0;
    logic [127:0] m_state = '0;
    logic [3:0]   m_den = '0;
    logic [3:0]   m_sen = '0;
    bit           m_done = 0;
    int           m_busy = 0;
    int           m_pend = 0;
    int           m_k = 0;

    localparam logic [127:0] LOW64 = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};

    pudding_dac_ctrl #(.N_UNITS(128), .N_EN(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .daisy_on(daisy_on), .state_on(state_on),
        .daisy_en(daisy_en), .state_en(state_en), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] thermo(input int kk);
        logic [127:0] one;
        one = 128'd1;
        if (kk >= 128) return '1;
        return (one << kk) - one;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        logic [127:0] nd, ns;
        logic [3:0]   nde, nse;
        int           nb, np, nk;
        bit           ndn;
        nd = m_daisy; ns = m_state; nde = m_den; nse = m_sen;
        nb = m_busy; np = m_pend; nk = m_k; ndn = 0;
        if (rst) begin
            nd = '0; ns = '0; nde = '0; nse = '0; nb = 0; np = 0; nk = 0;
        end else if (nb > 0) begin
            nb = nb - 1;
            if (np == 2 && nb == 1) ns = nd;
            if (nb == 0) begin
                if (np == 1) nd = thermo(nk);
                np = 0;
                ndn = 1;
            end
        end else if (cmd_valid) begin
            ndn = 1;
            case (cmd_op)
                3'b000: nd = {nd[126:0], cmd_data[0]};
                3'b001: begin
`ifdef PUDDING_DAC_BLANK_EN
                    nb = 2; np = 2; ndn = 0;
`else
                    ns = nd;
`endif
                end
                3'b010: nd = ns;
                3'b011: begin
                    nk = (cmd_data > 8'd128) ? 128 : int'(cmd_data);
                    nb = 128; np = 1; ndn = 0;
                end
                3'b100: begin
                    nse = cmd_data[3:0];
                    nde = cmd_data[7:4];
                end
                default: ;
            endcase
        end
        m_daisy <= nd; m_state <= ns; m_den <= nde; m_sen <= nse;
        m_busy <= nb; m_pend <= np; m_k <= nk; m_done <= ndn;
    end

    // Compare against the model between edges, once inputs driven at the falling edge have settled.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            checkOutput("cmd_ready", 128'(cmd_ready), 128'(!rst && m_busy == 0));
            checkOutput("done", 128'(done), 128'(m_done));
            if (!(m_pend == 1 && m_busy > 0)) checkOutput("daisy_on", daisy_on, m_daisy);
            checkOutput("state_on", state_on, m_state);
            checkOutput("daisy_en", 128'(daisy_en), 128'(m_den));
            checkOutput("state_en", 128'(state_en), 128'((m_pend == 2 && m_busy > 0) ? 4'h0 : m_sen));
            if (done) done_cnt++;
            if (!cmd_ready && !rst) ready_low_cnt++;
            if (state_en == 4'h0) sen_zero_cnt++;
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data);
        bit took;
        took = 0;
        cmd_op = op;
        cmd_data = data;
        cmd_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            took = cmd_ready;
            @(posedge clk);
            if (took) break;
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        if (!took) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept of op %0d", op);
        end
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 300; n++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got cmd_ready=0 expected 1 within 300 cycles");
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    task automatic clearCounts();
        done_cnt = 0;
        ready_low_cnt = 0;
        sen_zero_cnt = 0;
    endtask

    initial begin
        logic [127:0] snap_daisy;
        logic [127:0] snap_state;
        logic [7:0]   shift_bits;
        int           exp_dip;

        repeat (3) @(negedge clk);
        chk_en = 1;
        rst = 1'b0;
        #2;
        checkOutput("reset_daisy", daisy_on, 128'h0);
        checkOutput("reset_state", state_on, 128'h0);
        checkOutput("reset_en", 128'({daisy_en, state_en}), 128'h0);
        checkOutput("reset_ready", 128'(cmd_ready), 128'h1);

        $display("[TB] shift 1,0,1,1");
        clearCounts();
        shift_bits = 8'b0000_1101;
        for (int i = 0; i < 4; i++) applyStimulus(3'b000, {7'b0, shift_bits[i]});
        settle();
        checkOutput("shift_daisy", daisy_on, 128'hB);
        checkOutput("shift_done_cnt", 128'(done_cnt), 128'd4);
        checkOutput("shift_ready_low", 128'(ready_low_cnt), 128'd0);

        $display("[TB] thermo 5, 200, 0");
        clearCounts();
        applyStimulus(3'b011, 8'd5);
        waitIdle();
        settle();
        checkOutput("thermo5_daisy", daisy_on, 128'h1F);
        checkOutput("thermo5_ready_low", 128'(ready_low_cnt), 128'd128);
        checkOutput("thermo5_done_cnt", 128'(done_cnt), 128'd1);
        applyStimulus(3'b011, 8'd200);
        waitIdle();
        settle();
        checkOutput("thermo200_daisy", daisy_on, {128{1'b1}});
        applyStimulus(3'b011, 8'd0);
        waitIdle();
        settle();
        checkOutput("thermo0_daisy", daisy_on, 128'h0);

        $display("[TB] set_en and commit");
        applyStimulus(3'b100, 8'hA5);
        settle();
        checkOutput("set_en_daisy_en", 128'(daisy_en), 128'hA);
        checkOutput("set_en_state_en", 128'(state_en), 128'h5);
        applyStimulus(3'b011, 8'd64);
        waitIdle();
        settle();
        clearCounts();
        applyStimulus(3'b001, 8'h00);
        waitIdle();
        settle();
`ifdef PUDDING_DAC_BLANK_EN
        exp_dip = 2;
`else
        exp_dip = 0;
`endif
        checkOutput("commit_state_on", state_on, LOW64);
        checkOutput("commit_en_dip", 128'(sen_zero_cnt), 128'(exp_dip));
        checkOutput("commit_state_en", 128'(state_en), 128'h5);
        checkOutput("commit_done_cnt", 128'(done_cnt), 128'd1);

        $display("[TB] thermo 3 with ignored commands, then capture");
        applyStimulus(3'b011, 8'd3);
        cmd_op = 3'b000;
        cmd_data = 8'h01;
        cmd_valid = 1'b1;
        repeat (20) @(negedge clk);
        cmd_valid = 1'b0;
        waitIdle();
        settle();
        checkOutput("thermo3_daisy", daisy_on, 128'h7);
        applyStimulus(3'b010, 8'h00);
        settle();
        checkOutput("capture_daisy", daisy_on, LOW64);
        checkOutput("capture_state", state_on, LOW64);

        $display("[TB] reset during load");
        applyStimulus(3'b011, 8'd100);
        clearCounts();
        repeat (60) @(negedge clk);
        rst = 1'b1;
        settle();
        checkOutput("midrst_daisy", daisy_on, 128'h0);
        checkOutput("midrst_state", state_on, 128'h0);
        checkOutput("midrst_en", 128'({daisy_en, state_en}), 128'h0);
        checkOutput("midrst_done", 128'(done), 128'h0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ready", 128'(cmd_ready), 128'h1);
        repeat (3) settle();
        checkOutput("midrst_no_done", 128'(done_cnt), 128'd0);

        $display("[TB] reserved op");
        applyStimulus(3'b000, 8'h01);
        applyStimulus(3'b100, 8'h3C);
        applyStimulus(3'b001, 8'h00);
        waitIdle();
        settle();
        snap_daisy = daisy_on;
        snap_state = state_on;
        clearCounts();
        applyStimulus(3'b110, 8'hFF);
        settle();
        checkOutput("reserved_done_cnt", 128'(done_cnt), 128'd1);
        checkOutput("reserved_daisy", daisy_on, snap_daisy);
        checkOutput("reserved_state", state_on, snap_state);
        checkOutput("reserved_en", 128'({daisy_en, state_en}), 128'h3C);
        checkOutput("reserved_daisy_lit", daisy_on, 128'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pudding_dac_ctrl.md
# pudding_dac_ctrl

Synchronous command sequencer for the PUDDING dual current-steering DAC. It owns the 128-bit serial daisychain register, the 128-bit state register and the two 4-bit enable groups. These registers feed the inverter-pair buffers ahead of the two 128-unit DAC arrays. A single command port supports bit-level shifting, commit/capture transfers between chain and state, enable-group programming, and an autonomous 128-cycle thermometer-code load.

## Interface
Parameters:
- N_UNITS, 128, unit cells per DAC; fixed at 128, thermometer code range is 0..N_UNITS.
- N_EN, 4, enable groups per DAC.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  000 SHIFT, 001 COMMIT, 010 CAPTURE, 011 THERMO, 100 SET_EN; 101..111 reserved.
- cmd_data  in  8  operand; meaning depends on cmd_op.
- daisy_on  out  N_UNITS  chain register; drives DAC H unit inputs.
- state_on  out  N_UNITS  state register; drives DAC L unit inputs.
- daisy_en  out  N_EN  DAC H enable groups.
- state_en  out  N_EN  DAC L enable groups; subject to blanking.
- done  out  1  one-cycle pulse when any command completes.

## Operation
- A command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_ready = (fsm == IDLE) && !rst.
- SHIFT: daisy_on <= {daisy_on[126:0], cmd_data[0]}.
- COMMIT: state_on <= daisy_on. Sequencing is described under Configuration.
- CAPTURE: daisy_on <= state_on. state_on is unchanged.
- SET_EN: state_en <= cmd_data[3:0] and daisy_en <= cmd_data[7:4].
- THERMO: code k = min(cmd_data, 128). The FSM enters LOAD and runs a 7-bit counter i = 0..127. On each LOAD cycle it shifts in bit ((127 − i) < k).
  - After 128 shifts, daisy_on[j] = (j < k).
  - k = 0 gives all zeros. k ≥ 128 gives all ones.
  - The THERMO command does not commit.
- Reserved ops are accepted, change no register and pulse done.
- FSM states are IDLE, LOAD, and BLANK0/BLANK1 when blanking is compiled in.
  - IDLE → LOAD on THERMO accept. LOAD → IDLE after the 128th shift.
  - IDLE → BLANK0 on COMMIT accept (blanking only), BLANK0 → BLANK1, BLANK1 → IDLE.
- Commands presented while cmd_ready = 0 are ignored; the requester holds cmd_valid.
- Reset values: daisy_on = 0, state_on = 0, daisy_en = 0, state_en = 0, done = 0, fsm = IDLE.
- Reset mid-operation (LOAD or BLANK) aborts the command. All registers take their reset values and no done pulse is issued.

## Timing
- SHIFT, CAPTURE, SET_EN, reserved ops, and COMMIT without blanking:
  - The register update occurs on the accept edge.
  - done is high the following cycle.
  - cmd_ready stays high, so back-to-back accepts are allowed every cycle.
- THERMO:
  - Accept at edge E0; shifts occur on edges E1..E128.
  - cmd_ready is low from after E0 until after E128.
  - done is high in the cycle after E128; the next accept is possible at E129.
- COMMIT with blanking:
  - E0 accept: state_en output forced to 0 from after E0.
  - E1: state_on <= daisy_on.
  - E2: state_en output restored to the programmed value; done high after E2; next accept at E3.
- The programmed state_en register is never altered by blanking; only the output is masked.
- All outputs are registered; there is no combinational path from cmd_* to outputs other than cmd_ready ← rst.

## Configuration
- PUDDING_DAC_BLANK_EN defined: COMMIT uses the BLANK0/BLANK1 break-before-make sequence. state_en is driven 0 for exactly two cycles around the state update, suppressing switching glitches in DAC L.
- PUDDING_DAC_BLANK_EN undefined: BLANK states are not compiled. COMMIT is a single-cycle op like CAPTURE, and state_en never deasserts except via SET_EN or reset.

## Test plan
- Reset, then SHIFT bits 1,0,1,1 on consecutive cycles → daisy_on[3:0] = 4'b1011, upper bits 0, cmd_ready high throughout, four done pulses.
- THERMO k = 5 → cmd_ready low for exactly 128 cycles, then daisy_on = 128'h1F and a single done pulse. THERMO 200 → all ones. THERMO 0 → all zeros.
- SET_EN 8'hA5 → daisy_en = 4'hA and state_en = 4'h5. Then COMMIT with blanking → state_en = 0 for 2 cycles, state_on = daisy_on after the 2nd edge, state_en back to 4'h5. Without the macro: single-cycle commit with no state_en dip.
- Load chain with THERMO 64, COMMIT, THERMO 3, CAPTURE → daisy_on equals the lower 64 ones. Commands issued during LOAD are ignored and must not corrupt the chain.
- Assert rst at i = 60 of a THERMO load → next cycle all outputs 0, fsm IDLE, no done pulse, cmd_ready high after rst drops.
- Reserved op 3'b110 → no register change, done pulses once.
